mem_access_sched: RTL

//  Clocked round-robin scheduler sharing one single-port neuron/potential memory among NUM_REQ requesters (PE-side and NOC-side agents).

---
 rtl/mem_sched_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/mem_access_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the neuron/potential memory access scheduler.
package mem_sched_pkg;

  // Default neuron-array dimensions (timesteps x columns x rows).
  localparam int unsigned DEF_T_DIM = 2;
  localparam int unsigned DEF_X_DIM = 25;
  localparam int unsigned DEF_Y_DIM = 25;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } req_op_e;

  // Row-major linear address: timestep plane, then column, then row.
  function automatic int unsigned lin_addr(
    input int unsigned t,
    input int unsigned x,
    input int unsigned y,
    input int unsigned x_dim,
    input int unsigned y_dim
  );
    return t * x_dim * y_dim + x * y_dim + y;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr (mod NUM_REQ).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  // Rotating priority search starting at ptr; the first hit wins.
  always_comb begin
    int unsigned k;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!gnt_valid && req[IDX_W'(k)]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = IDX_W'(k);
        gnt[IDX_W'(k)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_sched.sv
// Round-robin scheduler sharing one single-port neuron memory among NUM_REQ requesters.
// One request is outstanding at a time; each in-range request makes exactly one memory access.
module mem_access_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned T_W     = 2,
  parameter int unsigned X_W     = 5,
  parameter int unsigned Y_W     = 5,
  parameter int unsigned T_DIM   = DEF_T_DIM,
  parameter int unsigned X_DIM   = DEF_X_DIM,
  parameter int unsigned Y_DIM   = DEF_Y_DIM,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ADDR_W  = $clog2(T_DIM * X_DIM * Y_DIM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*T_W-1:0]    req_t,
  input  logic [NUM_REQ*X_W-1:0]    req_x,
  input  logic [NUM_REQ*Y_W-1:0]    req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  req_op_e             op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;

  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic                xfer;

  logic [T_W-1:0]      sel_t;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_in_range;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Grant is only offered while idle and out of reset; a grant in IDLE is a transfer.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) begin
      req_ready = gnt;
    end
  end

  assign xfer = (state_q == IDLE) && gnt_valid;

  // Pick the granted requester's fields, range-check them and form the linear address.
  always_comb begin
    sel_t        = req_t[gnt_idx * T_W +: T_W];
    sel_x        = req_x[gnt_idx * X_W +: X_W];
    sel_y        = req_y[gnt_idx * Y_W +: Y_W];
    sel_wdata    = req_wdata[gnt_idx * DATA_W +: DATA_W];
    sel_in_range = (32'(sel_t) < T_DIM) && (32'(sel_x) < X_DIM) && (32'(sel_y) < Y_DIM);
    sel_addr     = ADDR_W'((ADDR_W + 2)'(lin_addr(32'(sel_t), 32'(sel_x), 32'(sel_y),
                                                  X_DIM, Y_DIM)));
  end

  // State register and all datapath/output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      lat_cnt_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state: out-of-range requests skip the memory and answer immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = sel_in_range ? ISSUE : RESP;
      ISSUE:   state_d = (op_q == OP_WRITE) ? RESP : WAIT;
      WAIT:    if (lat_cnt_q == LAT_W'(1)) state_d = RESP;
      RESP:    if (rsp_ready[idx_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter and registered memory/response outputs.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    lat_cnt_d   = lat_cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (xfer) begin
      idx_d    = gnt_idx;
      op_d     = req_write[gnt_idx] ? OP_WRITE : OP_READ;
      addr_d   = sel_addr;
      wdata_d  = sel_wdata;
      err_d    = !sel_in_range;
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    if (state_q == ISSUE) begin
      lat_cnt_d = LAT_W'(RD_LAT);
    end else if (state_q == WAIT) begin
      lat_cnt_d = lat_cnt_q - LAT_W'(1);
    end

    // The single memory strobe is raised for the cycle spent in ISSUE.
    if (state_d == ISSUE) begin
      mem_en_d   = 1'b1;
      mem_we_d   = (op_d == OP_WRITE);
      mem_addr_d = addr_d;
      if (op_d == OP_WRITE) begin
        mem_wdata_d = wdata_d;
      end
    end

    // Response is held stable for the whole RESP stay; read data is captured only from WAIT.
    if (state_d == RESP) begin
      rsp_valid_d[idx_d] = 1'b1;
      rsp_err_d          = err_d;
      if (state_q == WAIT) begin
        rsp_rdata_d = mem_rdata;
      end else if (state_q == RESP) begin
        rsp_rdata_d = rsp_rdata_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
